// File: rtl/io_irq_ctrl_if.sv
// Slave-side bus bundle for io_irq_ctrl: decoder select, strobes, address and data.
interface io_irq_ctrl_if;
  logic        nSel;
  logic [1:0]  BusAddr;
  logic        BusRead;
  logic        BusWrite;
  logic [15:0] BusDataIn;
  logic [15:0] BusDataOut;

  modport master (output nSel, BusAddr, BusRead, BusWrite, BusDataIn, input BusDataOut);
  modport slave  (input nSel, BusAddr, BusRead, BusWrite, BusDataIn, output BusDataOut);
endinterface

// File: rtl/io_irq_ctrl.sv
// Memory-mapped interrupt controller: edge capture, fixed priority, nIRQ pulse and ack/EOI sequencing.
// Optional re-pulse of an unacknowledged interrupt: define IRQ_RETRIG_EN.

// One request source: rising-edge detect into a sticky pending bit; a new edge beats a clear.
module io_irq_src (
  input  logic Clock,
  input  logic Reset,
  input  logic req,
  input  logic clr,
  output logic pend
);
  logic req_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      req_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      req_q <= req;
      if (req && !req_q) pend <= 1'b1;
      else if (clr)      pend <= 1'b0;
    end
  end
endmodule

module io_irq_ctrl #(
  parameter int NSRC          = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int RETRIG_CYCLES = 64
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NSRC-1:0]    IrqReq,
  io_irq_ctrl_if.slave       bus,
  output logic               nIRQ
);
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, WAIT_ACK = 2'd2, IN_SERVICE = 2'd3} state_t;

`ifdef IRQ_RETRIG_EN
  localparam int CMAX = (RETRIG_CYCLES > PULSE_CYCLES) ? RETRIG_CYCLES : PULSE_CYCLES;
`else
  localparam int CMAX = PULSE_CYCLES;
`endif
  localparam int CW = $clog2(CMAX + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [NSRC-1:0]   pend, mask, pm, clr, w1c_vec, ack_vec;
  logic [3:0]        idx, insvc;
  logic              insvc_vld, id_valid, rd, wr, ack, eoi;
  logic [15:0]       stat;
  logic              unused_ok;

  assign rd       = !bus.nSel && bus.BusRead;
  assign wr       = !bus.nSel && bus.BusWrite;
  assign pm       = pend & mask;
  assign id_valid = |pm;
  assign eoi      = wr && (bus.BusAddr == 2'd3);
  // An ID read only acknowledges while an interrupt is being offered to the CPU.
  assign ack      = rd && (bus.BusAddr == 2'd2) && id_valid &&
                    ((state == ASSERT) || (state == WAIT_ACK));
  assign unused_ok = ^bus.BusDataIn;

  always_comb begin
    idx = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (pm[i]) idx = 4'(i);
  end

  assign w1c_vec = (wr && bus.BusAddr == 2'd0) ? bus.BusDataIn[NSRC-1:0] : '0;
  assign ack_vec = ack ? (NSRC'(1) << idx) : '0;
  assign clr     = w1c_vec | ack_vec;

  io_irq_src u_src [NSRC-1:0] (
    .Clock (Clock),
    .Reset (Reset),
    .req   (IrqReq),
    .clr   (clr),
    .pend  (pend)
  );

  always_ff @(posedge Clock) begin
    if (Reset)                              mask <= '0;
    else if (wr && bus.BusAddr == 2'd1)     mask <= bus.BusDataIn[NSRC-1:0];
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      nIRQ      <= 1'b1;
      cnt       <= '0;
      insvc     <= 4'd0;
      insvc_vld <= 1'b0;
    end else begin
      if (ack) begin
        insvc     <= idx;
        insvc_vld <= 1'b1;
      end
      case (state)
        IDLE: if (id_valid) begin
          state <= ASSERT;
          nIRQ  <= 1'b0;
          cnt   <= '0;
        end
        ASSERT: begin
          if (ack) begin
            state <= IN_SERVICE;
            nIRQ  <= 1'b1;
          end else if (cnt == CW'(PULSE_CYCLES - 1)) begin
            state <= WAIT_ACK;
            nIRQ  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack)            state <= IN_SERVICE;
          else if (!id_valid) state <= IDLE;
`ifdef IRQ_RETRIG_EN
          else if (cnt == CW'(RETRIG_CYCLES - 1)) begin
            state <= ASSERT;
            nIRQ  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        IN_SERVICE: if (eoi) begin
          state     <= IDLE;
          insvc_vld <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status keeps a 3-bit index for small configurations and widens it beyond 8 sources.
  generate
    if (NSRC > 8) begin : g_stat_wide
      assign stat = {state, 9'b0, insvc_vld, insvc};
    end else begin : g_stat_narrow
      assign stat = {state, 10'b0, insvc_vld, insvc[2:0]};
    end
  endgenerate

  always_comb begin
    bus.BusDataOut = 16'h0000;
    if (rd) begin
      case (bus.BusAddr)
        2'd0:    bus.BusDataOut = 16'(pend);
        2'd1:    bus.BusDataOut = 16'(mask);
        2'd2:    bus.BusDataOut = id_valid ? {1'b1, 11'b0, idx} : 16'h0000;
        default: bus.BusDataOut = stat;
      endcase
    end
  end
endmodule
